grant_scheduler: RTL and testbench

Round-robin scheduler that shares one resource among NUM_REQUESTERS clients. It holds each grant until the owner signals its last cycle, drops its request, or exceeds a hold limit. The grant is delivered in two forms: a registered one-hot vector and a matching binary index. It sits in front of shared datapath resources (cache refill port, store queue, memory interface) and drives per-requester grant lines and the resource's select mux.

---
 rtl/grant_scheduler_if.sv | 32 +++
 rtl/grant_scheduler.sv | 117 +++++++++++
 tb/tb_grant_scheduler.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/grant_scheduler_if.sv
// grant_scheduler_if: request/last in, grant bundle out.
// master = requester side, slave = scheduler side.
interface grant_scheduler_if #(
  parameter int NUM_REQUESTERS = 7
) ();
  localparam int IDX_WIDTH = $clog2(NUM_REQUESTERS);

  logic [NUM_REQUESTERS-1:0] request;
  logic [NUM_REQUESTERS-1:0] last;
  logic                      grant_valid;
  logic [NUM_REQUESTERS-1:0] grant_oh;
  logic [IDX_WIDTH-1:0]      grant_idx;
  logic                      timeout;

  modport master (
    output request,
    output last,
    input  grant_valid,
    input  grant_oh,
    input  grant_idx,
    input  timeout
  );

  modport slave (
    input  request,
    input  last,
    output grant_valid,
    output grant_oh,
    output grant_idx,
    output timeout
  );
endinterface

// File: rtl/grant_scheduler.sv
// grant_scheduler: round-robin grant holder with hold limit.
// Registered one-hot and binary grant, one idle cycle between grants.
module grant_scheduler #(
  parameter int NUM_REQUESTERS = 7,
  parameter int MAX_HOLD       = 16
) (
  input logic               clk,
  input logic               reset,
  grant_scheduler_if.slave  bus
);
  localparam int IDX_WIDTH = $clog2(NUM_REQUESTERS);
  localparam int CNT_WIDTH = $clog2(MAX_HOLD + 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic [IDX_WIDTH-1:0]      ptr_q, ptr_d;
  logic [IDX_WIDTH-1:0]      idx_q, idx_d;
  logic [NUM_REQUESTERS-1:0] oh_q, oh_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
  logic                      to_q, to_d;

  logic [IDX_WIDTH-1:0]      win_idx;
  logic [NUM_REQUESTERS-1:0] win_oh;
  logic [IDX_WIDTH-1:0]      nxt_ptr;
  logic                      rel_norm;
  logic                      hit_max;

  // Find first request at or above ptr, wrapping at NUM_REQUESTERS.
  always_comb begin
    int   t;
    logic found;
    logic [IDX_WIDTH-1:0] cand;
    t       = 0;
    found   = 1'b0;
    cand    = '0;
    win_idx = '0;
    win_oh  = '0;
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      t = int'(ptr_q) + k;
      if (t >= NUM_REQUESTERS)
        t = t - NUM_REQUESTERS;
      cand = IDX_WIDTH'(t);
      if (!found && bus.request[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
    win_oh[win_idx] = 1'b1;
  end

  assign rel_norm = bus.last[idx_q] | ~bus.request[idx_q];
  assign hit_max  = (cnt_q == CNT_WIDTH'(MAX_HOLD));
  assign nxt_ptr  = (idx_q == IDX_WIDTH'(NUM_REQUESTERS - 1))
                  ? '0 : idx_q + 1'b1;

  // Next-state: grant in IDLE, hold or release in BUSY.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    oh_d    = oh_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|bus.request) begin
          state_d = BUSY;
          idx_d   = win_idx;
          oh_d    = win_oh;
          cnt_d   = CNT_WIDTH'(1);
        end
      end
      BUSY: begin
        unique case (1'b1)
          rel_norm, hit_max: begin
            state_d = IDLE;
            idx_d   = '0;
            oh_d    = '0;
            cnt_d   = '0;
            ptr_d   = nxt_ptr;
            to_d    = ~rel_norm;
          end
          default: cnt_d = cnt_q + 1'b1;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      oh_q    <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      oh_q    <= oh_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  assign bus.grant_valid = (state_q == BUSY);
  assign bus.grant_oh    = oh_q;
  assign bus.grant_idx   = idx_q;
  assign bus.timeout     = to_q;
endmodule

// File: tb/tb_grant_scheduler.sv
// tb_grant_scheduler: directed table plus random run
// against a round-robin reference model.
module tb_grant_scheduler;
  localparam int N  = 7;
  localparam int MH = 4;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_bad;

  grant_scheduler_if #(.NUM_REQUESTERS(N)) bus ();

  grant_scheduler #(
    .NUM_REQUESTERS(N),
    .MAX_HOLD(MH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] lst;
    logic         v;
    logic [2:0]   idx;
    logic         to;
  } vec_t;

  vec_t tbl[$];

  int m_ptr;
  int m_own;
  int m_held;
  bit m_to;

  function automatic void push(logic [N-1:0] r, logic [N-1:0] l,
                               logic v, int i, logic to);
    vec_t e;
    e.req = r;
    e.lst = l;
    e.v   = v;
    e.idx = 3'(i);
    e.to  = to;
    tbl.push_back(e);
  endfunction

  function automatic logic [11:0] exp_pack(logic v, int i, logic to);
    logic [N-1:0] oh;
    oh = '0;
    if (v) oh[i] = 1'b1;
    return {v, oh, (v ? 3'(i) : 3'd0), to};
  endfunction

  function automatic logic [11:0] dut_pack();
    return {bus.grant_valid, bus.grant_oh, bus.grant_idx, bus.timeout};
  endfunction

  function automatic void model_reset();
    m_ptr  = 0;
    m_own  = -1;
    m_held = 0;
    m_to   = 1'b0;
  endfunction

  function automatic void model_step(logic [N-1:0] r, logic [N-1:0] l);
    m_to = 1'b0;
    if (m_own < 0) begin
      for (int k = 0; k < N; k++) begin
        if (m_own < 0 && r[(m_ptr + k) % N]) begin
          m_own  = (m_ptr + k) % N;
          m_held = 1;
        end
      end
    end else if (l[m_own] || !r[m_own]) begin
      m_ptr = (m_own + 1) % N;
      m_own = -1;
    end else if (m_held == MH) begin
      m_ptr = (m_own + 1) % N;
      m_own = -1;
      m_to  = 1'b1;
    end else begin
      m_held++;
    end
  endfunction

  task automatic check(string name, logic [11:0] got, logic [11:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got v/oh/idx/to=%b required %b", name, got, exp);
    end
  endtask

  task automatic apply(logic [N-1:0] r, logic [N-1:0] l);
    bus.request = r;
    bus.last    = l;
    @(posedge clk);
    model_step(r, l);
    @(negedge clk);
  endtask

  task automatic check_model(string name);
    check(name, dut_pack(), exp_pack(m_own >= 0, (m_own < 0) ? 0 : m_own, m_to));
  endtask

  initial begin
    logic [N-1:0] all;
    logic [N-1:0] r;
    logic [N-1:0] l;
    n_vec = 0;
    n_bad = 0;
    all = '1;
    reset = 1'b0;
    bus.request = '0;
    bus.last = '0;
    model_reset();

    push(7'b0000100, 7'b0000100, 1, 2, 0);
    push(7'b0000100, 7'b0000100, 0, 0, 0);
    for (int g = 0; g < 7; g++) begin
      push(all, all, 1, (3 + g) % 7, 0);
      push(all, all, 0, 0, 0);
    end
    push(7'b1000000, 7'b1000000, 1, 6, 0);
    push(7'b1000000, 7'b1000000, 0, 0, 0);
    push(7'b1000001, 7'b1000001, 1, 0, 0);
    push(7'b1000001, 7'b1000001, 0, 0, 0);
    for (int c = 0; c < 4; c++)
      push(7'b0001000, 7'b0000000, 1, 3, 0);
    push(7'b0001000, 7'b0000000, 0, 0, 1);
    push(7'b0011000, 7'b0000000, 1, 4, 0);
    push(7'b0011000, 7'b0010000, 0, 0, 0);
    for (int c = 0; c < 4; c++)
      push(7'b0100000, 7'b0000000, 1, 5, 0);
    push(7'b0100000, 7'b0100000, 0, 0, 0);
    push(7'b0100000, 7'b0000000, 1, 5, 0);
    push(7'b0100000, 7'b1011111, 1, 5, 0);
    push(7'b0100000, 7'b1011111, 1, 5, 0);
    push(7'b0000000, 7'b1011111, 0, 0, 0);
    push(7'b0000000, 7'b0000000, 0, 0, 0);

    repeat (2) @(negedge clk);
    check("reset_state", dut_pack(), 12'd0);
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_idle", dut_pack(), 12'd0);

    foreach (tbl[i]) begin
      apply(tbl[i].req, tbl[i].lst);
      check($sformatf("table[%0d]", i), dut_pack(),
            exp_pack(tbl[i].v, int'(tbl[i].idx), tbl[i].to));
    end

    apply(7'b0010000, 7'b0000000);
    check("pre_reset_grant", dut_pack(), exp_pack(1, 4, 0));
    apply(7'b0010000, 7'b0000000);
    #2 reset = 1'b0;
    #1 check("async_reset_clear", dut_pack(), 12'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    apply(7'b0001000, 7'b0001000);
    check("restart_ptr0", dut_pack(), exp_pack(1, 3, 0));
    apply(7'b0001000, 7'b0001000);
    check("restart_release", dut_pack(), 12'd0);
    apply(7'b1000010, 7'b0000000);
    check("ptr_after_3", dut_pack(), exp_pack(1, 6, 0));
    apply(7'b0000000, 7'b0000000);
    check("drop_release", dut_pack(), 12'd0);

    r = '0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0)
        r = N'($urandom);
      l = N'($urandom) & N'($urandom) & N'($urandom);
      apply(r, l);
      check_model($sformatf("random[%0d]", c));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
